// File: rtl/greenhouse_pkg.sv
// Shared constants and encodings for the greenhouse HVAC scheduler.
package greenhouse_pkg;

    localparam int unsigned TH = 5;

    localparam logic [7:0] COOL_TH_MIN = 8'd90;
    localparam logic [7:0] COOL_TH_MAX = 8'd120;
    localparam logic [7:0] HEAT_TH_MIN = 8'd10;
    localparam logic [7:0] HEAT_TH_MAX = 8'd80;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_COOL = 2'b01,
        MODE_HEAT = 2'b10
    } mode_e;

    function automatic logic cfg_out_of_range(input logic [7:0] cool_th,
                                              input logic [7:0] heat_th);
        return (cool_th < COOL_TH_MIN) || (cool_th > COOL_TH_MAX) ||
               (heat_th < HEAT_TH_MIN) || (heat_th > HEAT_TH_MAX);
    endfunction

endpackage

// File: rtl/greenhouse_hvac_scheduler_rr_pick.sv
// Combinational round-robin finder: first set request after i_last, wrapping.
module rr_pick
    import greenhouse_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_last,
    output logic                 o_found,
    output logic [$clog2(N)-1:0] o_idx
);
    localparam int unsigned LW = $clog2(N);

    logic [LW-1:0] w_j;

    // Scan from the farthest offset down so the nearest requester after i_last wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_j     = '0;
        for (int i = N; i >= 1; i--) begin
            w_j = i_last + LW'(i);
            if (i_req[w_j]) begin
                o_found = 1'b1;
                o_idx   = w_j;
            end
        end
    end

endmodule

// File: rtl/greenhouse_hvac_scheduler.sv
// Shares one HVAC actuator between zones: round-robin grants, bounded run time,
// mandatory off-time between runs.
module greenhouse_hvac_scheduler
    import greenhouse_pkg::*;
#(
    parameter int unsigned N_ZONES = 4,
    parameter int unsigned MIN_ON  = 16,
    parameter int unsigned MAX_ON  = 200,
    parameter int unsigned MIN_OFF = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 cooldown_th,
    input  logic [7:0]                 heatup_th,
    input  logic [8*N_ZONES-1:0]       zone_temp,
    input  logic [N_ZONES-1:0]         zone_valid,
    output logic                       act_on,
    output logic [1:0]                 act_mode,
    output logic [$clog2(N_ZONES)-1:0] act_zone,
    output logic                       cfg_err
);
    localparam int unsigned ZW = $clog2(N_ZONES);
    localparam int unsigned RW = $clog2(MAX_ON + 1);
    localparam int unsigned OW = $clog2(MIN_OFF + 1);
    localparam logic signed [8:0] TH_S = 9'(TH);

    state_e        r_state;
    mode_e         r_act_mode;
    logic          r_act_on;
    logic [ZW-1:0] r_act_zone;
    logic [ZW-1:0] r_last;
    logic          r_cfg_err;
    logic [RW-1:0] r_run_cnt;
    logic [OW-1:0] r_off_cnt;

    logic signed [8:0]    w_temp [N_ZONES];
    logic signed [8:0]    w_cool_th;
    logic signed [8:0]    w_heat_th;
    logic signed [8:0]    w_cool_rel;
    logic signed [8:0]    w_heat_rel;
    logic signed [8:0]    w_sel_temp;
    logic [N_ZONES-1:0]   w_cool_req;
    logic [N_ZONES-1:0]   w_heat_req;
    logic [N_ZONES-1:0]   w_req;
    logic [N_ZONES-1:0]   w_others;
    logic                 w_other_req;
    logic                 w_release;
    logic                 w_cfg_err_c;
    logic                 w_found;
    logic [ZW-1:0]        w_pick;

    // Per-zone requests and release test, all in 9-bit signed so thresholds never wrap.
    always_comb begin
        w_cool_th  = $signed({1'b0, cooldown_th});
        w_heat_th  = $signed({1'b0, heatup_th});
        w_cool_rel = w_cool_th - TH_S;
        w_heat_rel = w_heat_th + TH_S;
        for (int i = 0; i < N_ZONES; i++) begin
            w_temp[i]     = $signed({zone_temp[8*i+7], zone_temp[8*i +: 8]});
            w_cool_req[i] = zone_valid[i] && (w_temp[i] >= w_cool_th);
            w_heat_req[i] = zone_valid[i] && (w_temp[i] <= w_heat_th);
        end
        w_req       = w_cool_req | w_heat_req;
        w_others    = w_req & ~(N_ZONES'(1) << r_act_zone);
        w_other_req = |w_others;
        w_sel_temp  = w_temp[r_act_zone];
        w_release   = !zone_valid[r_act_zone] ||
                      ((r_act_mode == MODE_COOL) ? (w_sel_temp <= w_cool_rel)
                                                 : (w_sel_temp >= w_heat_rel));
        w_cfg_err_c = cfg_out_of_range(cooldown_th, heatup_th);
    end

    rr_pick #(.N(N_ZONES)) u_rr_pick (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_act_on   <= 1'b0;
            r_act_mode <= MODE_OFF;
            r_act_zone <= '0;
            r_last     <= ZW'(N_ZONES - 1);
            r_cfg_err  <= 1'b0;
            r_run_cnt  <= '0;
            r_off_cnt  <= '0;
        end else begin
            r_cfg_err <= w_cfg_err_c;
            case (r_state)
                ST_IDLE: begin
                    if (!r_cfg_err && w_found) begin
                        r_state    <= ST_RUN;
                        r_act_on   <= 1'b1;
                        r_act_zone <= w_pick;
                        r_last     <= w_pick;
                        r_act_mode <= w_cool_req[w_pick] ? MODE_COOL : MODE_HEAT;
                        r_run_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    if (r_run_cnt < RW'(MAX_ON)) begin
                        r_run_cnt <= r_run_cnt + RW'(1);
                    end
                    // Pre-emption stays armed once the run has reached its limit.
                    if (r_cfg_err ||
                        (w_release && (r_run_cnt >= RW'(MIN_ON - 1))) ||
                        (w_other_req && (r_run_cnt >= RW'(MAX_ON - 1)))) begin
                        r_state    <= ST_HOLDOFF;
                        r_act_on   <= 1'b0;
                        r_act_mode <= MODE_OFF;
                        r_off_cnt  <= '0;
                    end
                end
                ST_HOLDOFF: begin
                    if (r_off_cnt >= OW'(MIN_OFF - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_off_cnt <= r_off_cnt + OW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign act_on   = r_act_on;
    assign act_mode = r_act_mode;
    assign act_zone = r_act_zone;
    assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_greenhouse_hvac_scheduler.sv
// Directed and randomized checks of the HVAC scheduler against a cycle-level behavioural model.
module tb_greenhouse_hvac_scheduler;

    localparam int N       = 4;
    localparam int MIN_ON  = 16;
    localparam int MAX_ON  = 200;
    localparam int MIN_OFF = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     cooldown_th;
    logic [7:0]     heatup_th;
    logic [8*N-1:0] zone_temp;
    logic [N-1:0]   zone_valid;
    logic           act_on;
    logic [1:0]     act_mode;
    logic [1:0]     act_zone;
    logic           cfg_err;

    int checks = 0;
    int errors = 0;

    // Model state: phase 0 idle, 1 running, 2 off-time
    int m_phase, m_len, m_off, m_last, m_zone, m_mode;
    bit m_on, m_cfg;

    greenhouse_hvac_scheduler #(
        .N_ZONES(N), .MIN_ON(MIN_ON), .MAX_ON(MAX_ON), .MIN_OFF(MIN_OFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cooldown_th (cooldown_th),
        .heatup_th   (heatup_th),
        .zone_temp   (zone_temp),
        .zone_valid  (zone_valid),
        .act_on      (act_on),
        .act_mode    (act_mode),
        .act_zone    (act_zone),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int temp_of(input int z);
        logic [7:0] b;
        int t;
        b = zone_temp[8*z +: 8];
        t = int'(b);
        if (t > 127) t -= 256;
        return t;
    endfunction

    function automatic bit cool_req(input int z);
        return zone_valid[z] && (temp_of(z) >= int'(cooldown_th));
    endfunction

    function automatic bit heat_req(input int z);
        return zone_valid[z] && (temp_of(z) <= int'(heatup_th));
    endfunction

    function automatic bit cfg_bad();
        return cooldown_th < 8'd90 || cooldown_th > 8'd120 ||
               heatup_th < 8'd10 || heatup_th > 8'd80;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_len = 0; m_off = 0; m_last = N - 1;
        m_zone = 0; m_mode = 0; m_on = 0; m_cfg = 0;
    endtask

    // Advance the model by one clock using the inputs the DUT sees at that edge.
    task automatic model_edge();
        bit nxt_cfg, rel, other;
        int t;
        nxt_cfg = cfg_bad();
        if (m_phase == 0) begin
            if (!m_cfg) begin
                for (int k = 1; k <= N; k++) begin
                    int z;
                    z = (m_last + k) % N;
                    if (cool_req(z) || heat_req(z)) begin
                        m_phase = 1; m_on = 1; m_zone = z; m_last = z;
                        m_mode = cool_req(z) ? 1 : 2;
                        m_len = 1;
                        break;
                    end
                end
            end
        end else if (m_phase == 1) begin
            t = temp_of(m_zone);
            rel = !zone_valid[m_zone] ||
                  ((m_mode == 1) ? (t <= int'(cooldown_th) - 5) : (t >= int'(heatup_th) + 5));
            other = 0;
            for (int z = 0; z < N; z++)
                if (z != m_zone && (cool_req(z) || heat_req(z))) other = 1;
            if (m_cfg || (rel && m_len >= MIN_ON) || (other && m_len >= MAX_ON)) begin
                m_phase = 2; m_on = 0; m_mode = 0; m_off = 1;
            end else begin
                m_len++;
            end
        end else begin
            if (m_off >= MIN_OFF) m_phase = 0;
            else m_off++;
        end
        m_cfg = nxt_cfg;
    endtask

    task automatic check_model();
        chk("act_on",   8'(act_on),   8'(m_on));
        chk("act_mode", 8'(act_mode), 8'(m_mode));
        chk("act_zone", 8'(act_zone), 8'(m_zone));
        chk("cfg_err",  8'(cfg_err),  8'(m_cfg));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_model();
        rst = 1'b0;
    endtask

    // Step until act_on reaches lvl; an exhausted budget shows up as a failed check.
    task automatic run_until(input logic lvl, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (act_on !== lvl && n < budget);
        chk("wait_act_on", 8'(act_on), 8'(lvl));
    endtask

    task automatic set_temp(input int z, input int t);
        zone_temp[8*z +: 8] = 8'(t);
    endtask

    function automatic int rand_temp();
        int r, v;
        r = int'($urandom_range(0, 3));
        v = int'($urandom_range(0, 16)) - 8;
        case (r)
            0: return int'($urandom_range(0, 255)) - 128;
            1: return int'(cooldown_th) + v;
            2: return int'(heatup_th) + v;
            default: return 70;
        endcase
    endfunction

    int n;
    int exp_order [3] = '{0, 1, 3};

    initial begin
        rst = 1'b1;
        cooldown_th = 8'd95;
        heatup_th   = 8'd60;
        zone_valid  = '1;
        for (int z = 0; z < N; z++) set_temp(z, 70);
        set_temp(2, 100);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_act_on",   8'(act_on),   8'd0);
        chk("rst_act_mode", 8'(act_mode), 8'd0);
        chk("rst_act_zone", 8'(act_zone), 8'd0);
        chk("rst_cfg_err",  8'(cfg_err),  8'd0);
        rst = 1'b0;

        // First grant right after reset release
        step();
        chk("first_on",   8'(act_on),   8'd1);
        chk("first_zone", 8'(act_zone), 8'd2);
        chk("first_mode", 8'(act_mode), 8'd1);

        // Hysteresis: 91 and 94 are above the release point of 90
        step(); step();
        set_temp(2, 91);
        repeat (5) step();
        set_temp(2, 94);
        repeat (15) step();
        chk("hyst_hold", 8'(act_on), 8'd1);
        set_temp(2, 90);
        step();
        chk("hyst_release", 8'(act_on), 8'd0);

        // Pending request during off-time: low for MIN_OFF, then one idle cycle
        set_temp(2, 100);
        for (int i = 0; i < MIN_OFF; i++) begin
            step();
            chk("gap_low", 8'(act_on), 8'd0);
        end
        step();
        chk("gap_regrant", 8'(act_on), 8'd1);

        // MIN_ON holds even when release is immediate
        set_temp(2, 90);
        for (int i = 1; i < MIN_ON; i++) begin
            step();
            chk("min_on_hold", 8'(act_on), 8'd1);
        end
        step();
        chk("min_on_release", 8'(act_on), 8'd0);

        // Round-robin among heat requesters 0, 1, 3 with MAX_ON pre-emption
        for (int z = 0; z < N; z++) set_temp(z, 50);
        set_temp(2, 70);
        do_reset();
        step();
        for (int r = 0; r < 3; r++) begin
            chk("rr_zone", 8'(act_zone), 8'(exp_order[r]));
            chk("rr_mode", 8'(act_mode), 8'd2);
            run_until(1'b0, 1000, n);
            chk("rr_len", 8'(n), 8'(MAX_ON));
            run_until(1'b1, 100, n);
            chk("rr_gap", 8'(n), 8'(MIN_OFF + 1));
        end
        chk("rr_wrap", 8'(act_zone), 8'd0);

        // Config error during a run
        heatup_th = 8'd85;
        step();
        chk("cfg_err_set", 8'(cfg_err), 8'd1);
        chk("cfg_err_still_on", 8'(act_on), 8'd1);
        step();
        chk("cfg_err_off", 8'(act_on), 8'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("cfg_err_no_grant", 8'(act_on), 8'd0);
        end
        heatup_th = 8'd60;
        run_until(1'b1, 100, n);

        // Signed extremes
        heatup_th = 8'd10;
        for (int z = 0; z < N; z++) set_temp(z, 70);
        set_temp(1, -128);
        do_reset();
        step();
        chk("neg_on",   8'(act_on),   8'd1);
        chk("neg_zone", 8'(act_zone), 8'd1);
        chk("neg_mode", 8'(act_mode), 8'd2);
        set_temp(1, 14);
        repeat (20) step();
        chk("neg_hold", 8'(act_on), 8'd1);
        set_temp(1, 15);
        step();
        chk("neg_release", 8'(act_on), 8'd0);
        set_temp(1, 70);
        set_temp(3, 127);
        cooldown_th = 8'd120;
        run_until(1'b1, 100, n);
        chk("hot_gap",  8'(n),        8'(MIN_OFF + 1));
        chk("hot_zone", 8'(act_zone), 8'd3);
        chk("hot_mode", 8'(act_mode), 8'd1);

        // Valid drop after MIN_ON
        repeat (20) step();
        zone_valid[3] = 1'b0;
        step();
        chk("valid_drop", 8'(act_on), 8'd0);
        zone_valid[3] = 1'b1;
        run_until(1'b1, 100, n);
        repeat (5) step();

        // Asynchronous reset mid-run
        rst = 1'b1;
        #2;
        chk("async_rst_on",   8'(act_on),   8'd0);
        chk("async_rst_mode", 8'(act_mode), 8'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_model();
        rst = 1'b0;

        // Randomized traffic against the model
        cooldown_th = 8'd100;
        heatup_th   = 8'd40;
        for (int z = 0; z < N; z++) set_temp(z, 70);
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int z = 0; z < N; z++) begin
                if ($urandom_range(0, 15) == 0) set_temp(z, rand_temp());
                if ($urandom_range(0, 63) == 0) zone_valid[z] = ~zone_valid[z];
            end
            if ($urandom_range(0, 299) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    cooldown_th = 8'($urandom_range(60, 200));
                    heatup_th   = 8'($urandom_range(0, 200));
                end else begin
                    cooldown_th = 8'($urandom_range(90, 120));
                    heatup_th   = 8'($urandom_range(10, 80));
                end
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
